// File: rtl/a_compare_seq.sv
// a_compare_seq -- step sequencer for the RS232 loopback compare checker.
// Holds DEPTH expected 18-bit words and runs the checker once per entry:
// clear checker, load expected value, enable, wait for flag/error/timeout,
// tally the result.
//
// Ports:
//   clk_ref, rst_n        clock (rising edge) and async active-low reset
//   cfg_we/addr/data      table write port (ignored while busy)
//   num_steps, start      run length (clamped to DEPTH) and run request
//   chk_rst_n, chk_enable, chk_comp_val   registered checker controls
//   chk_flag, chk_error   sticky checker match / mismatch
//   busy, done, cur_step  run status
//   pass_cnt, fail_cnt, tmo_cnt           per-run result counters
module a_compare_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int TMO_W = 10
) (
  input  logic          clk_ref,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [17:0]   cfg_data,
  input  logic [AW:0]   num_steps,
  input  logic          start,
  output logic          chk_rst_n,
  output logic          chk_enable,
  output logic [17:0]   chk_comp_val,
  input  logic          chk_flag,
  input  logic          chk_error,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_step,
  output logic [AW:0]   pass_cnt,
  output logic [AW:0]   fail_cnt,
  output logic [AW:0]   tmo_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_WAIT, S_NEXT, S_DONE
  } state_t;

  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_C   = (AW+1)'(1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  state_t            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [AW:0]       nsteps_q, nsteps_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [AW:0]       pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic [17:0]       comp_q, comp_d;
  logic              chk_rst_n_q, chk_rst_n_d;
  logic              chk_enable_q, chk_enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [17:0]       tbl_q [DEPTH];
  logic              tbl_wr;

  // busy_q is exactly "state is CLEAR/ARM/WAIT/NEXT", so it gates writes.
  assign tbl_wr = cfg_we & ~busy_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    timer_d  = timer_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    comp_d   = comp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d = '0;
          fail_d = '0;
          tmo_d  = '0;
          if (num_steps == '0) begin
            state_d = S_DONE;
          end else begin
            nsteps_d = (num_steps > DEPTH_C) ? DEPTH_C : num_steps;
            step_d   = '0;
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        // Loaded at the end of CLEAR so a table write coinciding with start
        // is already visible.
        comp_d  = tbl_q[step_q];
        state_d = S_ARM;
      end
      S_ARM: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Compare the incremented value so WAIT lasts 2**TMO_W-1 cycles.
        timer_d = timer_q + 1'b1;
        if (chk_error) begin
          fail_d  = fail_q + ONE_C;
          state_d = S_NEXT;
        end else if (chk_flag) begin
          pass_d  = pass_q + ONE_C;
          state_d = S_NEXT;
        end else if (timer_d == TMO_MAX) begin
          tmo_d   = tmo_q + ONE_C;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if ({1'b0, step_q} == nsteps_q - ONE_C) begin
          state_d = S_DONE;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they line up with it.
    chk_rst_n_d  = (state_d != S_CLEAR);
    chk_enable_d = (state_d == S_ARM) || (state_d == S_WAIT);
    busy_d       = (state_d == S_CLEAR) || (state_d == S_ARM) ||
                   (state_d == S_WAIT)  || (state_d == S_NEXT);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      nsteps_q     <= '0;
      timer_q      <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      tmo_q        <= '0;
      comp_q       <= '0;
      chk_rst_n_q  <= 1'b1;
      chk_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      nsteps_q     <= nsteps_d;
      timer_q      <= timer_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      tmo_q        <= tmo_d;
      comp_q       <= comp_d;
      chk_rst_n_q  <= chk_rst_n_d;
      chk_enable_q <= chk_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (tbl_wr) tbl_q[cfg_addr] <= cfg_data;
    end
  end

  assign chk_rst_n    = chk_rst_n_q;
  assign chk_enable   = chk_enable_q;
  assign chk_comp_val = comp_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_step     = step_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign tmo_cnt      = tmo_q;

endmodule

// File: tb/tb_a_compare_seq.sv
// Testbench for a_compare_seq: table-driven runs against a behavioural
// checker model plus hand-written multi-cycle sequences.
module tb_a_compare_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic [3:0]  num_steps;
  logic        start;
  logic        chk_rst_n, chk_enable;
  logic [17:0] chk_comp_val;
  logic        chk_flag = 1'b0, chk_error = 1'b0;
  logic        busy, done;
  logic [2:0]  cur_step;
  logic [3:0]  pass_cnt, fail_cnt, tmo_cnt;

  a_compare_seq #(.DEPTH(8), .AW(3), .TMO_W(10)) dut (
    .clk_ref(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_steps(num_steps), .start(start),
    .chk_rst_n(chk_rst_n), .chk_enable(chk_enable), .chk_comp_val(chk_comp_val),
    .chk_flag(chk_flag), .chk_error(chk_error),
    .busy(busy), .done(done), .cur_step(cur_step),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  // Checker model. mode: 0 = no data (timeout), 1/2 = compare received
  // word m_rx against chk_comp_val, 3 = raise flag and error together.
  int          m_mode [8];
  logic [17:0] m_rx   [8];
  int          ecnt = 0;
  int          done_cnt = 0;
  int          pulse_cnt = 0;
  logic        prev_rstn = 1'b1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_rstn && !chk_rst_n) pulse_cnt++;
    prev_rstn = chk_rst_n;
    if (!chk_rst_n) begin
      chk_flag  = 1'b0;
      chk_error = 1'b0;
      ecnt      = 0;
    end else if (chk_enable) begin
      ecnt++;
      if (ecnt == 3) begin
        if (m_mode[cur_step] == 3) begin
          chk_flag  = 1'b1;
          chk_error = 1'b1;
        end else if (m_mode[cur_step] != 0) begin
          if (chk_comp_val == m_rx[cur_step]) chk_flag = 1'b1;
          else chk_error = 1'b1;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0][17:0] tbl;
    logic [7:0][1:0]  mode;
    logic [3:0]       n;
    int ep, ef, et, ecur, epulse;
  } vec_t;

  vec_t vecs [5];

  task automatic load_tbl(input logic [7:0][17:0] t);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'(j); cfg_data = t[j];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] n);
    @(negedge clk);
    start = 1'b1; num_steps = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, int'(done), 1);
  endtask

  task automatic run_vec(input int i);
    int d0, p0;
    vec_t v;
    string nm;
    v  = vecs[i];
    nm = $sformatf("vec%0d", i);
    load_tbl(v.tbl);
    for (int j = 0; j < 8; j++) begin
      m_mode[j] = int'(v.mode[j]);
      m_rx[j]   = (v.mode[j] == 2'd2) ? (v.tbl[j] ^ 18'h00001) : v.tbl[j];
    end
    d0 = done_cnt; p0 = pulse_cnt;
    do_start(v.n);
    wait_done(nm);
    repeat (2) @(negedge clk);
    check({nm, "_pass"},   int'(pass_cnt), v.ep);
    check({nm, "_fail"},   int'(fail_cnt), v.ef);
    check({nm, "_tmo"},    int'(tmo_cnt),  v.et);
    check({nm, "_cur"},    int'(cur_step), v.ecur);
    check({nm, "_dones"},  done_cnt - d0,  1);
    check({nm, "_clrs"},   pulse_cnt - p0, v.epulse);
  endtask

  initial begin
    int c, d0, k;
    logic [7:0][17:0] t;

    // Vector table
    t = '0; t[0] = 18'h00001; t[1] = 18'h3FFFF; t[2] = 18'h15555;
    vecs[0] = '{tbl: t, mode: {10'd0, 2'd1, 2'd1, 2'd1}, n: 4'd3,
                ep: 3, ef: 0, et: 0, ecur: 2, epulse: 3};
    vecs[1] = '{tbl: t, mode: {10'd0, 2'd1, 2'd2, 2'd1}, n: 4'd3,
                ep: 2, ef: 1, et: 0, ecur: 2, epulse: 3};
    for (int j = 0; j < 8; j++) t[j] = 18'(j * 18'h01111 + 5);
    vecs[2] = '{tbl: t, mode: {8{2'd1}}, n: 4'd12,
                ep: 8, ef: 0, et: 0, ecur: 7, epulse: 8};
    vecs[3] = '{tbl: t, mode: {8{2'd1}}, n: 4'd0,
                ep: 0, ef: 0, et: 0, ecur: 7, epulse: 0};
    t = '0; t[0] = 18'h2AAAA; t[1] = 18'h00F0F; t[2] = 18'h3C3C3; t[3] = 18'h12345;
    // step0 flag+error (error wins), step1 pass, step2 mismatch, step3 pass
    vecs[4] = '{tbl: t, mode: {8'd0, 2'd1, 2'd2, 2'd1, 2'd3}, n: 4'd4,
                ep: 2, ef: 2, et: 0, ecur: 3, epulse: 4};

    for (int j = 0; j < 8; j++) begin m_mode[j] = 0; m_rx[j] = '0; end
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_steps = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_chkrn", int'(chk_rst_n), 1);
    check("rst_en",    int'(chk_enable), 0);
    check("rst_comp",  int'(chk_comp_val), 0);
    check("rst_cnts",  int'(pass_cnt) + int'(fail_cnt) + int'(tmo_cnt), 0);
    check("rst_cur",   int'(cur_step), 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // num_steps=0: done immediately after the accepting edge, never busy
    d0 = done_cnt;
    do_start(4'd0);
    check("zero_done_now", int'(done), 1);
    check("zero_busy",     int'(busy), 0);

    // Timeout step: CLEAR to DONE spans 1026 cycles
    m_mode[0] = 0;
    do_start(4'd1);
    k = 0;
    while (chk_rst_n && k < 20) begin @(negedge clk); k++; end
    check("tmo_clear_seen", int'(chk_rst_n), 0);
    c = 0;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    check("tmo_len", c, 1026);
    check("tmo_cnt", int'(tmo_cnt), 1);
    check("tmo_pass", int'(pass_cnt), 0);

    // Writes and start while busy are ignored
    t = '0; t[0] = 18'h00001; t[1] = 18'h3FFFF; t[2] = 18'h15555;
    load_tbl(t);
    for (int j = 0; j < 3; j++) begin m_mode[j] = 1; m_rx[j] = t[j]; end
    d0 = done_cnt;
    do_start(4'd3);
    k = 0;
    while (!chk_enable && k < 20) begin @(negedge clk); k++; end
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 18'h00ABC;
    start = 1'b1; num_steps = 4'd1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done("busy_ign");
    repeat (2) @(negedge clk);
    check("busy_ign_pass",  int'(pass_cnt), 3);
    check("busy_ign_fail",  int'(fail_cnt), 0);
    check("busy_ign_cur",   int'(cur_step), 2);
    check("busy_ign_dones", done_cnt - d0, 1);

    // Reset during WAIT of step 1
    m_mode[1] = 0;
    d0 = done_cnt;
    do_start(4'd3);
    k = 0;
    while (!(cur_step == 3'd1 && chk_enable) && k < 50) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    check("mid_pass_before", int'(pass_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",  int'(busy), 0);
    check("mid_en",    int'(chk_enable), 0);
    check("mid_chkrn", int'(chk_rst_n), 1);
    check("mid_cnt",   int'(pass_cnt) + int'(fail_cnt) + int'(tmo_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_no_done", done_cnt - d0, 0);

    // Table was cleared by reset: entry 0 now presents 0
    m_mode[0] = 1; m_rx[0] = 18'h00000;
    do_start(4'd1);
    wait_done("clr_tbl");
    check("clr_tbl_pass", int'(pass_cnt), 1);
    check("clr_tbl_fail", int'(fail_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
